ps2_kbd_ctrl: RTL and testbench
===============================

# ps2_kbd_ctrl

Keyboard input controller between the PS/2 scan-to-ASCII decoder and the CPU's memory-mapped I/O port. It queues decoded characters in a small FIFO, sequences CPU reads of data and status through a registered one-cycle response handshake, and tracks overflow. It can optionally raise an interrupt while characters are pending. It replaces the single-entry hold of the keyboard path with a decoupled queue, so bursts of keystrokes are not lost while the CPU is busy.

## Interface
- DEPTH_LOG2, 3, log2 of FIFO depth; depth D = 2^DEPTH_LOG2 (8 by default)
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ps2_write  in  1  one-cycle strobe: ps2_ascii valid, push request
- ps2_ascii  in  8  decoded character
- cpu_rd  in  1  one-cycle read strobe
- cpu_wr  in  1  one-cycle write strobe
- cpu_addr  in  1  0 = DATA, 1 = STATUS/CONTROL
- cpu_wdata  in  8  write data; used only for STATUS/CONTROL writes
- cpu_rdata  out  8  registered read data
- cpu_rvalid  out  1  high for exactly one cycle, the cycle after an accepted cpu_rd
- count  out  DEPTH_LOG2+1  current FIFO occupancy, 0..D
- irq  out  1  interrupt request, level; present only with KBD_IRQ_EN

## Operation
- Storage: D x 8 array, write pointer wp, read pointer rp (DEPTH_LOG2 bits each, wrap modulo D), and an occupancy counter cnt. empty = (cnt == 0). full = (cnt == D).
- Push: ps2_write && !full writes ps2_ascii at wp, then wp++ and cnt++. If ps2_write && full && no pop in the same cycle, the character is dropped and sticky ovf is set.
- Pop: cpu_rd && cpu_addr==0 && !empty. The entry at rp is latched into cpu_rdata, then rp++ and cnt--. cpu_rd on DATA while empty returns 0x00 and does not pop.
- Push and pop in the same cycle:
  - Not empty: both happen and cnt is unchanged; when full this also does not set ovf.
  - Empty: the pop returns 0x00, the push is accepted, and cnt becomes 1. There is no bypass.
- STATUS read (cpu_addr==1): rdata = {irq_pend, cnt[3:0] saturated to 15, ovf, full, !empty} in bits [7:0] as [7], [6:3], [2], [1], [0]. irq_pend is 0 when KBD_IRQ_EN is undefined.
- CONTROL write (cpu_wr && cpu_addr==1):
  - bit0 = 1 clears ovf.
  - bit1 = 1 flushes: wp = rp = cnt = 0.
  - bit2 loads irq_en (meaningful only with KBD_IRQ_EN).
- CPU write to DATA is ignored.
- Priority:
  - Flush beats a same-cycle push or pop. The push is dropped and does not set ovf; a pop returns 0x00.
  - An ovf set event beats a same-cycle ovf clear.
- Response FSM:
  - RIDLE → RRESP on any cpu_rd. cpu_rdata is loaded in that edge.
  - RRESP asserts cpu_rvalid, then returns to RIDLE. Another cpu_rd in RRESP is accepted back-to-back, so the FSM stays in RRESP.
  - cpu_rdata holds its value until the next accepted read.
- Simultaneous cpu_rd and cpu_wr: both are honoured. The read observes pre-write state.

## Timing
- Reset values: wp = rp = cnt = 0, ovf = 0, irq_en = 0, FSM = RIDLE, cpu_rdata = 0x00, cpu_rvalid = 0, count = 0, irq = 0.
- Reset asserted mid-operation discards FIFO contents and any pending response immediately.
- count reflects a push or pop from the edge that performs it.
- Data latency:
  - A push at edge N is poppable by a cpu_rd sampled at edge N+1.
  - Data appears on cpu_rdata after edge N+1, with cpu_rvalid high in that cycle.
- Read latency is 1 cycle. Sustained throughput is one read per cycle.
- irq is registered: irq = irq_en && !empty. It rises one cycle after the first push into an empty FIFO with irq_en = 1, and falls one cycle after the pop that empties the FIFO or after a flush.

## Configuration
- KBD_IRQ_EN defined: the irq port, the irq_en control bit and STATUS bit7 exist as described.
- KBD_IRQ_EN undefined:
  - No irq port, no irq_en register.
  - CONTROL bit2 is ignored.
  - STATUS bit7 reads 0.
  - All other behaviour is identical.

## Test plan
- Reset, then push 'A' (0x41) and 'B' (0x42), then two DATA reads → rdata 0x41 then 0x42 with rvalid in consecutive cycles; count goes 2 → 1 → 0; STATUS reads 0x00.
- Push 9 characters into D=8 with no reads → count = 8; STATUS = 0x47 (cnt 8, ovf, full, not_empty); the 9th character is absent on drain; CONTROL write 0x01 clears ovf.
- FIFO full, push 0x5A and DATA read in the same cycle → oldest entry returned, count stays 8, ovf stays 0; 0x5A is the last character drained.
- DATA read while empty → rdata 0x00, rvalid 1, count 0. Same-cycle push 0x31 on empty → read returns 0x00, count = 1.
- Three entries queued, flush write 0x02 concurrent with ps2_write 0x33 → count = 0, ovf = 0, subsequent DATA read returns 0x00.
- KBD_IRQ_EN: write 0x04, push 0x61 → irq high one cycle later; DATA read → irq low one cycle after the pop. Assert rst_n low mid-burst → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ps2_kbd_ctrl_if.sv
// Bus bundle between the keyboard controller and its surroundings:
// the PS/2 decoder push strobe, the CPU read/write port and the
// registered read response with FIFO occupancy.
interface ps2_kbd_ctrl_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  ps2_write;
    logic [7:0]            ps2_ascii;
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic                  cpu_addr;
    logic [7:0]            cpu_wdata;
    logic [7:0]            cpu_rdata;
    logic                  cpu_rvalid;
    logic [DEPTH_LOG2:0]   count;

    // Drives characters and CPU accesses, observes responses
    modport master (
        output ps2_write, ps2_ascii, cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rvalid, count
    );

    // The controller itself
    modport slave (
        input  ps2_write, ps2_ascii, cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rvalid, count
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard input controller: queues decoded characters in a
// 2^DEPTH_LOG2 x 8 FIFO, serves CPU DATA/STATUS reads through a
// registered one-cycle response, tracks a sticky overflow flag and
// accepts CONTROL writes (clear ovf, flush, irq enable).
// Optional feature macro: KBD_IRQ_EN adds the irq port, the irq_en
// control bit and STATUS bit7; without it those read/behave as zero.
module ps2_kbd_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    ps2_kbd_ctrl_if.slave   bus
`ifdef KBD_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int                    D       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   D_CNT   = (DEPTH_LOG2 + 1)'(D);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    localparam logic [0:0] RIDLE = 1'b0;
    localparam logic [0:0] RRESP = 1'b1;

    // Occupancy shown in STATUS is a 4-bit field that saturates at 15
    function automatic logic [3:0] sat_cnt4(input logic [DEPTH_LOG2:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        if (c32 > 32'd15) begin
            return 4'd15;
        end else begin
            return c32[3:0];
        end
    endfunction

    logic [7:0]            mem_q [0:D-1];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [0:0]            state_q, state_d;
    logic [7:0]            rdata_q, rdata_d;

    logic       empty_s, full_s;
    logic       rd_data_s, ctrl_wr_s, flush_s;
    logic       pop_s, push_s, ovf_set_s;
    logic       irq_pend_s;
    logic [7:0] status_s;

    // Decode accesses and resolve push/pop/flush priority for this cycle
    always_comb begin
        empty_s   = (cnt_q == '0);
        full_s    = (cnt_q == D_CNT);
        rd_data_s = bus.cpu_rd && (bus.cpu_addr == 1'b0);
        ctrl_wr_s = bus.cpu_wr && (bus.cpu_addr == 1'b1);
        flush_s   = ctrl_wr_s && bus.cpu_wdata[1];
        // Flush wins: a concurrent pop returns zero, a concurrent push is lost silently
        pop_s     = rd_data_s && !empty_s && !flush_s;
        // A pop in the same cycle frees the slot a full FIFO needs
        push_s    = bus.ps2_write && !flush_s && (!full_s || pop_s);
        ovf_set_s = bus.ps2_write && !flush_s && full_s && !pop_s;
        status_s  = {irq_pend_s, sat_cnt4(cnt_q), ovf_q, full_s, !empty_s};
    end

    // Next pointers, occupancy and sticky overflow
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_s) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_s) begin
                wp_d = wp_q + PTR_ONE;
            end else begin
                wp_d = wp_q;
            end
            if (pop_s) begin
                rp_d = rp_q + PTR_ONE;
            end else begin
                rp_d = rp_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
        // Setting overflow beats clearing it in the same cycle
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ctrl_wr_s && bus.cpu_wdata[0]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Read response: data is sampled from pre-write state and held until the next read
    always_comb begin
        rdata_d = rdata_q;
        if (bus.cpu_rd) begin
            if (bus.cpu_addr == 1'b1) begin
                rdata_d = status_s;
            end else if (pop_s) begin
                rdata_d = mem_q[rp_q];
            end else begin
                rdata_d = 8'h00;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Response FSM: every read, including back-to-back ones, yields one valid cycle
    always_comb begin
        case (state_q)
            RIDLE:   state_d = bus.cpu_rd ? RRESP : RIDLE;
            RRESP:   state_d = bus.cpu_rd ? RRESP : RIDLE;
            default: state_d = RIDLE;
        endcase
    end

    // FIFO storage; contents are discarded on reset through the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wp_q] <= bus.ps2_ascii;
        end
    end

    // Control and response state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= RIDLE;
            rdata_q <= 8'h00;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_rvalid = (state_q == RRESP);
    assign bus.count      = cnt_q;

`ifdef KBD_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // Interrupt enable load and level interrupt computed from the current queue state
    always_comb begin
        if (ctrl_wr_s) begin
            irq_en_d = bus.cpu_wdata[2];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_pend_s = irq_en_q && !empty_s;
        irq_d      = irq_pend_s;
    end

    // Interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    logic unused_wdata_s;
    assign unused_wdata_s = ^bus.cpu_wdata[7:3];
`else
    assign irq_pend_s = 1'b0;

    logic unused_wdata_s;
    assign unused_wdata_s = ^bus.cpu_wdata[7:2];
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed scenarios followed by
// random traffic, compared every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;
    localparam int DEPTH_LOG2 = 3;
    localparam int D = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_kbd_ctrl_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus_if ();
`ifdef KBD_IRQ_EN
    logic irq;
`endif

    ps2_kbd_ctrl #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef KBD_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    byte unsigned mq[$];
    bit           m_ovf, m_irq_en, m_irq, m_rvalid;
    logic [7:0]   m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
    endtask

    function automatic logic [7:0] m_status();
        int n = mq.size();
        int s = (n > 15) ? 15 : n;
        return {(m_irq_en && n != 0), 4'(s), m_ovf, (n == D), (n != 0)};
    endfunction

    // One clock of the behavioural rules: read, then flush or push, then flags
    task automatic model_step(input bit ps2w, input logic [7:0] ascii, input bit rd,
                              input bit wr, input bit addr, input logic [7:0] wdata);
        int n_pre;
        bit flush, popped, ovf_set;
        n_pre   = mq.size();
        flush   = wr && addr && wdata[1];
        popped  = 1'b0;
        ovf_set = 1'b0;
        m_irq   = m_irq_en && (n_pre != 0);
        m_rvalid = rd;
        if (rd) begin
            if (addr) m_rdata = m_status();
            else if (n_pre != 0 && !flush) begin
                m_rdata = mq.pop_front();
                popped = 1'b1;
            end else m_rdata = 8'h00;
        end
        if (flush) mq.delete();
        else if (ps2w) begin
            if (n_pre < D || popped) mq.push_back(ascii);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (wr && addr && wdata[0]) m_ovf = 1'b0;
`ifdef KBD_IRQ_EN
        if (wr && addr) m_irq_en = wdata[2];
`endif
    endtask

    task automatic step(input bit ps2w, input logic [7:0] ascii, input bit rd,
                        input bit wr, input bit addr, input logic [7:0] wdata, input string tag);
        bus_if.ps2_write = ps2w;
        bus_if.ps2_ascii = ascii;
        bus_if.cpu_rd    = rd;
        bus_if.cpu_wr    = wr;
        bus_if.cpu_addr  = addr;
        bus_if.cpu_wdata = wdata;
        @(posedge clk);
        #1;
        bus_if.ps2_write = 1'b0;
        bus_if.cpu_rd    = 1'b0;
        bus_if.cpu_wr    = 1'b0;
        model_step(ps2w, ascii, rd, wr, addr, wdata);
        chk({tag, ".rvalid"}, 32'(bus_if.cpu_rvalid), 32'(m_rvalid));
        chk({tag, ".rdata"},  32'(bus_if.cpu_rdata),  32'(m_rdata));
        chk({tag, ".count"},  32'(bus_if.count),      32'(mq.size()));
`ifdef KBD_IRQ_EN
        chk({tag, ".irq"},    32'(irq),               32'(m_irq));
`endif
    endtask

    task automatic push(input logic [7:0] c, input string tag);
        step(1'b1, c, 1'b0, 1'b0, 1'b0, 8'h00, tag);
    endtask
    task automatic rd_data(input string tag);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, tag);
    endtask
    task automatic rd_stat(input string tag);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, tag);
    endtask
    task automatic wr_ctrl(input logic [7:0] v, input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, v, tag);
    endtask
    task automatic idle(input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] wd;
        bit         a;
        rst_n = 1'b0;
        bus_if.ps2_write = 1'b0; bus_if.ps2_ascii = 8'h00;
        bus_if.cpu_rd = 1'b0; bus_if.cpu_wr = 1'b0;
        bus_if.cpu_addr = 1'b0; bus_if.cpu_wdata = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rdata",  32'(bus_if.cpu_rdata),  32'h00);
        chk("reset.rvalid", 32'(bus_if.cpu_rvalid), 32'h0);
        chk("reset.count",  32'(bus_if.count),      32'h0);
`ifdef KBD_IRQ_EN
        chk("reset.irq",    32'(irq),               32'h0);
`endif
        rst_n = 1'b1;

        // Two characters in, two out back-to-back
        push(8'h41, "ab.pushA");
        push(8'h42, "ab.pushB");
        chk("ab.count2", 32'(bus_if.count), 32'd2);
        rd_data("ab.rd1");
        chk("ab.rd1val", 32'(bus_if.cpu_rdata), 32'h41);
        chk("ab.count1", 32'(bus_if.count), 32'd1);
        rd_data("ab.rd2");
        chk("ab.rd2val", 32'(bus_if.cpu_rdata), 32'h42);
        chk("ab.rv2",    32'(bus_if.cpu_rvalid), 32'h1);
        rd_stat("ab.stat");
        chk("ab.statval", 32'(bus_if.cpu_rdata), 32'h00);

        // Overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++) push(8'(8'h50 + i), "ovf.push");
        chk("ovf.count", 32'(bus_if.count), 32'd8);
        rd_stat("ovf.stat");
        chk("ovf.statval", 32'(bus_if.cpu_rdata), 32'h47);
        for (int i = 0; i < 8; i++) rd_data("ovf.drain");
        chk("ovf.last", 32'(bus_if.cpu_rdata), 32'h57);
        wr_ctrl(8'h01, "ovf.clr");
        rd_stat("ovf.stat2");
        chk("ovf.cleared", 32'(bus_if.cpu_rdata), 32'h00);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i), "fp.fill");
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, "fp.both");
        chk("fp.oldest", 32'(bus_if.cpu_rdata), 32'h60);
        chk("fp.count",  32'(bus_if.count), 32'd8);
        rd_stat("fp.stat");
        chk("fp.statval", 32'(bus_if.cpu_rdata), 32'h43);
        for (int i = 0; i < 8; i++) rd_data("fp.drain");
        chk("fp.last", 32'(bus_if.cpu_rdata), 32'h5A);

        // Empty reads, and push concurrent with a read of an empty FIFO
        rd_data("em.rd");
        chk("em.rdval", 32'(bus_if.cpu_rdata), 32'h00);
        chk("em.rv",    32'(bus_if.cpu_rvalid), 32'h1);
        step(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 8'h00, "em.both");
        chk("em.nobypass", 32'(bus_if.cpu_rdata), 32'h00);
        chk("em.count1",   32'(bus_if.count), 32'd1);
        rd_data("em.rd31");
        chk("em.val31", 32'(bus_if.cpu_rdata), 32'h31);

        // Flush beats a concurrent push
        push(8'h01, "fl.p"); push(8'h02, "fl.p"); push(8'h03, "fl.p");
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h02, "fl.flush");
        chk("fl.count", 32'(bus_if.count), 32'd0);
        rd_stat("fl.stat");
        chk("fl.statval", 32'(bus_if.cpu_rdata), 32'h00);
        rd_data("fl.rd");
        chk("fl.rdval", 32'(bus_if.cpu_rdata), 32'h00);

        // Interrupt enable write; STATUS bit7 only exists with the feature
        wr_ctrl(8'h04, "irq.en");
        push(8'h61, "irq.push");
        idle("irq.wait");
`ifdef KBD_IRQ_EN
        chk("irq.high", 32'(irq), 32'h1);
`endif
        rd_stat("irq.stat");
        rd_data("irq.pop");
        idle("irq.wait2");
`ifdef KBD_IRQ_EN
        chk("irq.low", 32'(irq), 32'h0);
`endif
        wr_ctrl(8'h00, "irq.dis");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            wd = 8'($urandom);
            if ($urandom_range(3) != 0) wd[1] = 1'b0;
            a = ($urandom_range(2) == 0);
            step(($urandom_range(1) == 1), 8'($urandom),
                 ($urandom_range(2) == 0), ($urandom_range(7) == 0), a, wd, "rnd");
        end

        // Asynchronous reset in the middle of a burst
        wr_ctrl(8'h05, "rst.en");
        push(8'h71, "rst.p"); push(8'h72, "rst.p"); push(8'h73, "rst.p");
        rd_data("rst.rd");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.rdata",  32'(bus_if.cpu_rdata),  32'h00);
        chk("rst.rvalid", 32'(bus_if.cpu_rvalid), 32'h0);
        chk("rst.count",  32'(bus_if.count),      32'h0);
`ifdef KBD_IRQ_EN
        chk("rst.irq",    32'(irq),               32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_data("rst.after");
        chk("rst.afterval", 32'(bus_if.cpu_rdata), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
